// File: rtl/loop_filter_pi_gear.sv
// Fixed-point PI loop filter with acquisition/tracking gear sets and lock detection.
// Optional leaky integrator enabled by defining LF_LEAK_EN.
module loop_filter_pi_gear #(
    parameter int ERR_W     = 16,
    parameter int INT_W     = 32,
    parameter int OUT_W     = 24,
    parameter int KP_ACQ_SH = 4,
    parameter int KI_ACQ_SH = 10,
    parameter int KP_TRK_SH = 6,
    parameter int KI_TRK_SH = 14,
    parameter int LOCK_THR  = 512,
    parameter int LOCK_CNT  = 64,
    parameter int LEAK_SH   = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic signed [ERR_W-1:0] err_i,
    input  logic                    err_valid_i,
    input  logic                    freeze_i,
    input  logic                    clear_i,
    output logic signed [OUT_W-1:0] ctrl_o,
    output logic                    ctrl_valid_o,
    output logic                    locked_o,
    output logic                    sat_o
);
    localparam logic [0:0] ST_ACQ = 1'b0;
    localparam logic [0:0] ST_TRK = 1'b1;
    localparam int CNT_W = $clog2(LOCK_CNT + 1);
    localparam int SH    = INT_W - ERR_W;
    localparam int DSH   = INT_W - OUT_W;

    localparam logic signed [INT_W-1:0] IMAX = {1'b0, {(INT_W-1){1'b1}}};
    localparam logic signed [INT_W-1:0] IMIN = {1'b1, {(INT_W-1){1'b0}}};
    localparam logic signed [OUT_W-1:0] OMAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] OMIN = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [ERR_W-1:0] EMIN = {1'b1, {(ERR_W-1){1'b0}}};
    localparam logic [ERR_W-1:0] EMAX = {1'b0, {(ERR_W-1){1'b1}}};
    localparam logic [ERR_W-1:0] THR  = ERR_W'(LOCK_THR);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CNT - 1);

    logic [0:0]              state;
    logic [CNT_W-1:0]        cnt;
    logic signed [INT_W-1:0] integ;

    logic signed [INT_W-1:0] e, p, i_inc, integ_n;
    logic signed [INT_W+1:0] acc;
    logic signed [INT_W:0]   sum, sh;
    logic signed [OUT_W-1:0] ctrl_n;
    logic                    iclamp, oclamp, qual, hit;
    logic [ERR_W-1:0]        abs_err;
`ifdef LF_LEAK_EN
    logic signed [INT_W-1:0] leak;
`endif

    assign e = {err_i, {SH{1'b0}}};
    assign locked_o = (state == ST_TRK);

    always_comb begin
        p     = (state == ST_TRK) ? (e >>> KP_TRK_SH) : (e >>> KP_ACQ_SH);
        i_inc = (state == ST_TRK) ? (e >>> KI_TRK_SH) : (e >>> KI_ACQ_SH);
`ifdef LF_LEAK_EN
        leak  = integ >>> LEAK_SH;
        acc   = {{2{integ[INT_W-1]}}, integ} - {{2{leak[INT_W-1]}}, leak}
              + {{2{i_inc[INT_W-1]}}, i_inc};
`else
        acc   = {{2{integ[INT_W-1]}}, integ} + {{2{i_inc[INT_W-1]}}, i_inc};
`endif
        // Result fits INT_W only when the top three bits agree.
        iclamp = ~freeze_i & ~(&acc[INT_W+1:INT_W-1]) & (|acc[INT_W+1:INT_W-1]);
        if (freeze_i)
            integ_n = integ;
        else if (iclamp)
            integ_n = acc[INT_W+1] ? IMIN : IMAX;
        else
            integ_n = acc[INT_W-1:0];

        sum    = {integ_n[INT_W-1], integ_n} + {p[INT_W-1], p};
        sh     = sum >>> DSH;
        oclamp = ~(&sh[INT_W:OUT_W-1]) & (|sh[INT_W:OUT_W-1]);
        ctrl_n = oclamp ? (sh[INT_W] ? OMIN : OMAX) : sh[OUT_W-1:0];

        // Most-negative input maps to max positive so |err| never wraps.
        if (!err_i[ERR_W-1])
            abs_err = err_i;
        else if (err_i == EMIN)
            abs_err = EMAX;
        else
            abs_err = -err_i;
        qual = (abs_err <= THR);
        hit  = (state == ST_TRK) ? ~qual : qual;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_ACQ;
            cnt          <= '0;
            integ        <= '0;
            ctrl_o       <= '0;
            ctrl_valid_o <= 1'b0;
            sat_o        <= 1'b0;
        end else if (clear_i) begin
            state        <= ST_ACQ;
            cnt          <= '0;
            integ        <= '0;
            ctrl_o       <= '0;
            ctrl_valid_o <= 1'b0;
            sat_o        <= 1'b0;
        end else begin
            ctrl_valid_o <= err_valid_i;
            if (err_valid_i) begin
                integ  <= integ_n;
                ctrl_o <= ctrl_n;
                sat_o  <= iclamp | oclamp;
                if (!freeze_i) begin
                    if (!hit) begin
                        cnt <= '0;
                    end else if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= ~state;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_loop_filter_pi_gear.sv
// Directed bench for loop_filter_pi_gear: arithmetic reference model plus literal pins.
module tb_loop_filter_pi_gear;
    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic signed [15:0] err_i = '0;
    logic               err_valid_i = 1'b0;
    logic               freeze_i = 1'b0;
    logic               clear_i = 1'b0;
    logic signed [23:0] ctrl_o;
    logic               ctrl_valid_o, locked_o, sat_o;

    int checks = 0;
    int errors = 0;

    loop_filter_pi_gear dut (
        .clk(clk), .reset_n(reset_n), .err_i(err_i), .err_valid_i(err_valid_i),
        .freeze_i(freeze_i), .clear_i(clear_i), .ctrl_o(ctrl_o),
        .ctrl_valid_o(ctrl_valid_o), .locked_o(locked_o), .sat_o(sat_o)
    );

    always #5 clk = ~clk;

    localparam longint IMAX = 64'sd2147483647;
    localparam longint IMIN = -64'sd2147483648;
    localparam longint OMAX = 64'sd8388607;
    localparam longint OMIN = -64'sd8388608;

    // Reference model: plain integer arithmetic on the filter equations.
    longint m_integ, m_ctrl;
    int     m_cnt;
    bit     m_trk, m_vld, m_sat;

    always @(posedge clk or negedge reset_n) begin
        longint e, p, inc, t, s, o;
        int a;
        if (!reset_n) begin
            m_integ = 0; m_ctrl = 0; m_cnt = 0; m_trk = 0; m_vld = 0; m_sat = 0;
        end else if (clear_i) begin
            m_integ = 0; m_ctrl = 0; m_cnt = 0; m_trk = 0; m_vld = 0; m_sat = 0;
        end else if (err_valid_i) begin
            e   = longint'(err_i) * 65536;
            p   = e >>> (m_trk ? 6 : 4);
            inc = e >>> (m_trk ? 14 : 10);
            m_sat = 0;
            if (!freeze_i) begin
`ifdef LF_LEAK_EN
                t = m_integ - (m_integ >>> 16) + inc;
`else
                t = m_integ + inc;
`endif
                if (t > IMAX) begin t = IMAX; m_sat = 1; end
                if (t < IMIN) begin t = IMIN; m_sat = 1; end
                m_integ = t;
                a = (err_i < 0) ? -int'(err_i) : int'(err_i);
                if (a > 32767) a = 32767;
                if (m_trk ? (a > 512) : (a <= 512)) begin
                    m_cnt++;
                    if (m_cnt == 64) begin m_cnt = 0; m_trk = !m_trk; end
                end else m_cnt = 0;
            end
            s = m_integ + p;
            o = s >>> 8;
            if (o > OMAX) begin o = OMAX; m_sat = 1; end
            if (o < OMIN) begin o = OMIN; m_sat = 1; end
            m_ctrl = o;
            m_vld  = 1;
        end else begin
            m_vld = 0;
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("ctrl_o", longint'(ctrl_o), m_ctrl);
        chk("ctrl_valid_o", longint'(ctrl_valid_o), longint'(m_vld));
        chk("locked_o", longint'(locked_o), longint'(m_trk));
        chk("sat_o", longint'(sat_o), longint'(m_sat));
    end

    task automatic drv(input int e, input bit v, input bit f, input bit c);
        @(negedge clk);
        err_i = 16'(e); err_valid_i = v; freeze_i = f; clear_i = c;
    endtask

    task automatic run(input int e, input int n);
        for (int k = 0; k < n; k++) drv(e, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic settle();
        @(posedge clk); #1;
    endtask

    typedef struct { int e; bit v; bit f; } vec_t;
    vec_t mix [10] = '{
        '{-300, 1, 0}, '{0, 0, 0}, '{5000, 1, 0}, '{-32768, 1, 0}, '{77, 1, 1},
        '{0, 0, 0}, '{-1, 1, 0}, '{32767, 1, 1}, '{-511, 1, 0}, '{513, 1, 0}
    };

    initial begin
        #1;
        chk("reset ctrl_o", longint'(ctrl_o), 0);
        chk("reset locked_o", longint'(locked_o), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        drv(256, 1, 0, 0); settle();
        chk("first ctrl_o", longint'(ctrl_o), 4160);
        chk("first valid", longint'(ctrl_valid_o), 1);
        chk("first model integ", m_integ, 16384);
        drv(0, 0, 0, 0); settle();
        chk("idle valid", longint'(ctrl_valid_o), 0);
        chk("idle hold ctrl_o", longint'(ctrl_o), 4160);

        drv(0, 0, 0, 1);
        run(100, 63); settle();
        chk("63 not locked", longint'(locked_o), 0);
        run(100, 1); settle();
        chk("64 locked", longint'(locked_o), 1);
        chk("acq integ", m_integ, 409600);
        run(256, 1); settle();
        chk("track ctrl_o", longint'(ctrl_o), 2628);

        run(1000, 32); run(0, 1); run(1000, 32); settle();
        chk("gap keeps lock", longint'(locked_o), 1);
        run(1000, 31); settle();
        chk("63 far still locked", longint'(locked_o), 1);
        run(1000, 1); settle();
        chk("unlock", longint'(locked_o), 0);

        drv(0, 0, 0, 1);
        run(32767, 1100); settle();
        chk("pos sat ctrl_o", longint'(ctrl_o), OMAX);
        chk("pos sat_o", longint'(sat_o), 1);
        chk("pos integ", m_integ, IMAX);
        drv(0, 0, 0, 1);
        run(-32768, 1100); settle();
        chk("neg sat ctrl_o", longint'(ctrl_o), OMIN);
        chk("neg sat_o", longint'(sat_o), 1);
        chk("neg integ", m_integ, IMIN);

        drv(0, 0, 0, 1);
        run(256, 1);
        drv(256, 1, 1, 0); settle();
        chk("freeze ctrl_o", longint'(ctrl_o), 4160);
        chk("freeze integ", m_integ, 16384);
        chk("freeze valid", longint'(ctrl_valid_o), 1);

        foreach (mix[k]) drv(mix[k].e, mix[k].v, mix[k].f, 1'b0);
        drv(0, 0, 0, 0);

        run(300, 3);
        @(posedge clk); #3;
        reset_n = 1'b0; #1;
        chk("async ctrl_o", longint'(ctrl_o), 0);
        chk("async valid", longint'(ctrl_valid_o), 0);
        @(negedge clk); #1;
        reset_n = 1'b1;

        run(200, 2);
        drv(256, 1, 1, 1); settle();
        chk("clear ctrl_o", longint'(ctrl_o), 0);
        chk("clear valid", longint'(ctrl_valid_o), 0);
        chk("clear locked", longint'(locked_o), 0);
        drv(0, 0, 0, 0);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
